// File: rtl/text_overlay_engine.sv
// Character-grid text overlay keyed over the upstream pixel stream, glyph rows from an external sync font ROM.
// Latency: 3 clk from in_* to out_* (counters/box/map read, font fetch, colour select).
// No backpressure on the pixel path; chr_ready stays low while the char map is being cleared.
module text_overlay_engine #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 16,
    parameter int COLS     = 32,
    parameter int ROWS     = 4,
    localparam int AW      = $clog2(COLS * ROWS),
    localparam int LW      = $clog2(GLYPH_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_de,
    input  logic               in_hs,
    input  logic               in_vs,
    input  logic [23:0]        in_rgb,
    input  logic               ov_enable,
    input  logic [11:0]        ov_x,
    input  logic [11:0]        ov_y,
    input  logic [1:0]         ov_scale,
    input  logic [23:0]        fg_rgb,
    input  logic [23:0]        bg_rgb,
    input  logic               bg_transparent,
    input  logic               chr_we,
    input  logic [AW-1:0]      chr_addr,
    input  logic [7:0]         chr_data,
    output logic               chr_ready,
    output logic [7+LW:0]      font_addr,
    input  logic [GLYPH_W-1:0] font_data,
    output logic               out_de,
    output logic               out_hs,
    output logic               out_vs,
    output logic [23:0]        out_rgb
);

    localparam int N_ENT = COLS * ROWS;
    localparam int BW    = $clog2(GLYPH_W);
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [AW:0] N_ENT_W = (AW + 1)'(N_ENT);
    localparam logic [AW:0] N_LAST  = (AW + 1)'(N_ENT - 1);
    localparam logic [11:0] X_MAX   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE - 1);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [7:0]    chr_map [N_ENT];

    logic [11:0]   x, y;
    logic          de_d, vs_d;
    logic          vs_rise;

    logic          cfg_en, cfg_tr;
    logic [11:0]   cfg_x, cfg_y;
    logic [1:0]    cfg_scale;
    logic [23:0]   cfg_fg, cfg_bg;

    logic [12:0]   box_w, box_h, dx, dy, rx, ry;
    logic          in_box;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [BW-1:0] bitx;
    logic [LW-1:0] line;
    logic [AW:0]   idx_w;
    logic [7:0]    code;

    logic          p1_de, p1_hs, p1_vs, p1_on;
    logic [23:0]   p1_rgb;
    logic [BW-1:0] p1_bitx;
    logic          p2_de, p2_hs, p2_vs, p2_on;
    logic [23:0]   p2_rgb;
    logic [BW-1:0] p2_bitx;

    logic [BW-1:0] sel;
    logic          glyph_bit;
    logic [23:0]   mux_rgb;

    assign vs_rise = in_vs && !vs_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_nxt;
    end

    // FSM next state: leave CLEAR once the last entry has been written
    always_comb begin
        state_nxt = state;
        chr_ready = 1'b0;
        case (state)
            ST_CLEAR: if ({1'b0, clr_cnt} == N_LAST) state_nxt = ST_IDLE;
            ST_IDLE:  chr_ready = 1'b1;
        endcase
    end

    // Clear sweep pointer, restarts from entry 0 on every reset
    always_ff @(posedge clk) begin
        if (rst)                  clr_cnt <= '0;
        else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    // Char map: space-fill during CLEAR, host writes only when ready and in range
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                chr_map[clr_cnt] <= 8'h20;
            else if (chr_we && ({1'b0, chr_addr} < N_ENT_W))
                chr_map[chr_addr] <= chr_data;
        end
    end

    // Raster counters and frame-synchronous config capture
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            de_d      <= 1'b0;
            vs_d      <= 1'b0;
            cfg_en    <= 1'b0;
            cfg_x     <= '0;
            cfg_y     <= '0;
            cfg_scale <= '0;
            cfg_fg    <= '0;
            cfg_bg    <= '0;
            cfg_tr    <= 1'b0;
        end else begin
            de_d <= in_de;
            vs_d <= in_vs;
            if (in_de) x <= (x == X_MAX) ? x : x + 12'd1;
            else       x <= '0;
            if (vs_rise)
                y <= '0;
            else if (de_d && !in_de && (y != Y_MAX))
                y <= y + 12'd1;
            if (vs_rise) begin
                cfg_en    <= ov_enable;
                cfg_x     <= ov_x;
                cfg_y     <= ov_y;
                cfg_scale <= ov_scale;
                cfg_fg    <= fg_rgb;
                cfg_bg    <= bg_rgb;
                cfg_tr    <= bg_transparent;
            end
        end
    end

    // Box test and glyph coordinates; 13-bit arithmetic so the box never wraps to x/y=0
    always_comb begin
        box_w  = 13'(COLS * GLYPH_W) << cfg_scale;
        box_h  = 13'(ROWS * GLYPH_H) << cfg_scale;
        dx     = {1'b0, x} - {1'b0, cfg_x};
        dy     = {1'b0, y} - {1'b0, cfg_y};
        rx     = dx >> cfg_scale;
        ry     = dy >> cfg_scale;
        in_box = in_de
              && ({1'b0, x} >= {1'b0, cfg_x}) && ({1'b0, x} < ({1'b0, cfg_x} + box_w))
              && ({1'b0, y} >= {1'b0, cfg_y}) && ({1'b0, y} < ({1'b0, cfg_y} + box_h));
        col    = CW'(rx >> BW);
        bitx   = BW'(rx);
        row    = RW'(ry >> LW);
        line   = LW'(ry);
        idx_w  = (AW + 1)'(int'(row) * COLS + int'(col));
        code   = (idx_w < N_ENT_W) ? chr_map[idx_w[AW-1:0]] : 8'h20;
    end

    // S1 -> S2: issue the ROM fetch and carry the pixel alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            font_addr <= '0;
            p1_de     <= 1'b0;
            p1_hs     <= 1'b0;
            p1_vs     <= 1'b0;
            p1_rgb    <= '0;
            p1_on     <= 1'b0;
            p1_bitx   <= '0;
        end else begin
            font_addr <= {code, line};
            p1_de     <= in_de;
            p1_hs     <= in_hs;
            p1_vs     <= in_vs;
            p1_rgb    <= in_rgb;
            p1_on     <= in_box && cfg_en && (state == ST_IDLE);
            p1_bitx   <= bitx;
        end
    end

    // S2 -> S3: wait out the ROM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            p2_de   <= 1'b0;
            p2_hs   <= 1'b0;
            p2_vs   <= 1'b0;
            p2_rgb  <= '0;
            p2_on   <= 1'b0;
            p2_bitx <= '0;
        end else begin
            p2_de   <= p1_de;
            p2_hs   <= p1_hs;
            p2_vs   <= p1_vs;
            p2_rgb  <= p1_rgb;
            p2_on   <= p1_on;
            p2_bitx <= p1_bitx;
        end
    end

    // Colour select: glyph bit picks FG, otherwise BG or the upstream pixel
    always_comb begin
        sel       = BW'(GLYPH_W - 1) - p2_bitx;
        glyph_bit = font_data[sel];
        mux_rgb   = p2_rgb;
        if (!p2_de)
            mux_rgb = '0;
        else if (p2_on) begin
            if (glyph_bit)    mux_rgb = cfg_fg;
            else if (!cfg_tr) mux_rgb = cfg_bg;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_de  <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_rgb <= '0;
        end else begin
            out_de  <= p2_de;
            out_hs  <= p2_hs;
            out_vs  <= p2_vs;
            out_rgb <= mux_rgb;
        end
    end

endmodule

// File: tb/tb_text_overlay_engine.sv
// Bench for text_overlay_engine: randomized frames compared against a pixel-coordinate reference model.
// Expected output of a pixel driven at step n is compared with the output sampled at step n+3.
// Font ROM is a synchronous model with one cycle of latency.
module tb_text_overlay_engine;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int GW   = 8;
    localparam int GH   = 16;
    localparam int COLS = 32;
    localparam int ROWS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_de, in_hs, in_vs;
    logic [23:0] in_rgb;
    logic        ov_enable;
    logic [11:0] ov_x, ov_y;
    logic [1:0]  ov_scale;
    logic [23:0] fg_rgb, bg_rgb;
    logic        bg_transparent;
    logic        chr_we;
    logic [6:0]  chr_addr;
    logic [7:0]  chr_data;
    logic        chr_ready;
    logic [11:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic        out_de, out_hs, out_vs;
    logic [23:0] out_rgb;

    text_overlay_engine dut (
        .clk(clk), .rst(rst),
        .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_rgb(in_rgb),
        .ov_enable(ov_enable), .ov_x(ov_x), .ov_y(ov_y), .ov_scale(ov_scale),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .bg_transparent(bg_transparent),
        .chr_we(chr_we), .chr_addr(chr_addr), .chr_data(chr_data), .chr_ready(chr_ready),
        .font_addr(font_addr), .font_data(font_data),
        .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;

    // Glyph pattern: odd multiplier keeps distinct codes distinct on any given line
    function automatic logic [7:0] rom(input logic [7:0] code, input logic [3:0] line);
        logic [7:0] a, b;
        a = 8'(int'(code) * 59);
        b = 8'(int'(line) * 17);
        return a ^ b;
    endfunction

    always @(posedge clk) font_data <= rom(font_addr[11:4], font_addr[3:0]);

    int tests = 0;
    int fails = 0;

    typedef logic [26:0] obs_t;
    obs_t act_q[$];
    obs_t exp_q[$];

    logic        m_en = 1'b0, m_tr = 1'b0;
    int          m_ox = 0, m_oy = 0, m_s = 0;
    logic [23:0] m_fg = '0, m_bg = '0;
    logic [7:0]  m_map [COLS*ROWS];
    logic        last_vs = 1'b0;
    logic [23:0] ramp = '0;
    int          rgb_mode = 0;
    int          llen[$];
    int          mid_line = -1;
    int          mid_ox = 0;

    function automatic logic [23:0] model_rgb(input logic [23:0] rgb, input int px, input int py);
        int w, h, rx, ry;
        logic [7:0] code, bits;
        w = (COLS * GW) << m_s;
        h = (ROWS * GH) << m_s;
        if (!m_en || px < m_ox || px >= m_ox + w || py < m_oy || py >= m_oy + h) return rgb;
        rx   = (px - m_ox) >> m_s;
        ry   = (py - m_oy) >> m_s;
        code = m_map[(ry / GH) * COLS + rx / GW];
        bits = rom(code, 4'(ry % GH));
        if (bits[GW - 1 - rx % GW]) return m_fg;
        return m_tr ? rgb : m_bg;
    endfunction

    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic [23:0] rgb, input int px, input int py);
        @(negedge clk);
        act_q.push_back({out_de, out_hs, out_vs, out_rgb});
        in_de  = de;
        in_hs  = hs;
        in_vs  = vs;
        in_rgb = rgb;
        if (vs && !last_vs) begin
            m_en = ov_enable;  m_ox = int'(ov_x);  m_oy = int'(ov_y);  m_s = int'(ov_scale);
            m_fg = fg_rgb;     m_bg = bg_rgb;      m_tr = bg_transparent;
        end
        last_vs = vs;
        exp_q.push_back({de, hs, vs, de ? model_rgb(rgb, px, py) : 24'h0});
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        chr_we   = 1'b1;
        chr_addr = 7'(a);
        chr_data = d;
        if (chr_ready) m_map[a] = d;
        step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        chr_we = 1'b0;
    endtask

    task automatic set_cfg(input logic en, input int x, input int y, input int s, input logic tr);
        ov_enable      = en;
        ov_x           = 12'(x);
        ov_y           = 12'(y);
        ov_scale       = 2'(s);
        bg_transparent = tr;
        fg_rgb         = 24'($urandom);
        bg_rgb         = fg_rgb ^ 24'h80C0A0;
    endtask

    task automatic drive_frame();
        logic [23:0] pix;
        repeat (2) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 24'h0, 0, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        for (int i = 0; i < llen.size(); i++) begin
            if (i == mid_line) ov_x = 12'(mid_ox);
            for (int p = 0; p < llen[i]; p++) begin
                pix = (rgb_mode == 1) ? ramp : 24'($urandom);
                ramp = ramp + 24'd1;
                step(1'b1, 1'b0, 1'b0, pix, p, i);
            end
            step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
            repeat (2) step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
            repeat (2) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;  in_de = 1'b1;  in_hs = 1'b1;  in_vs = 1'b1;  in_rgb = 24'hFFFFFF;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({out_de, out_hs, out_vs, out_rgb, font_addr, chr_ready} !== 40'h0) begin
                fails++;
                $display("FAIL reset_outputs: got %h required 0",
                         {out_de, out_hs, out_vs, out_rgb, font_addr, chr_ready});
            end
        end
        in_de = 1'b0;  in_hs = 1'b0;  in_vs = 1'b0;  in_rgb = 24'h0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        tests++;
        if (chr_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_mid_clear: got %b required 0", chr_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (chr_ready === 1'b0 && cnt < 1000) begin
            cnt++;
            chr_we   = 1'b1;
            chr_addr = 7'($urandom);
            chr_data = 8'($urandom_range(8'h21, 8'hFF));
            @(negedge clk);
        end
        chr_we = 1'b0;
        tests++;
        if (cnt != COLS * ROWS) begin
            fails++;
            $display("FAIL clear_cycles: got %0d required %0d", cnt, COLS * ROWS);
        end
        tests++;
        if (chr_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_clear: got %b required 1", chr_ready);
        end
        foreach (m_map[i]) m_map[i] = 8'h20;
    endtask

    task automatic test_clear_map();
        act_q.delete(); exp_q.delete();
        set_cfg(1'b1, 0, 0, 0, 1'b0);
        llen.delete();
        for (int y = 0; y < ROWS * GH; y++) llen.push_back((y % GH == 3) ? COLS * GW : 1);
        mid_line = -1;  rgb_mode = 0;
        drive_frame();
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL clear_map step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    task automatic test_glyph();
        act_q.delete(); exp_q.delete();
        wr(0, 8'h41);
        set_cfg(1'b1, 100, 50, 0, 1'b0);
        llen.delete();
        for (int y = 0; y < 68; y++) llen.push_back((y < 50) ? 1 : 120);
        drive_frame();
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL glyph step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    task automatic test_scale();
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < COLS; c += 3) wr(c, 8'($urandom));
        wr(COLS - 1, 8'hFF);
        set_cfg(1'b1, 100, 0, 2, 1'b0);
        llen.delete();
        repeat (4) llen.push_back(1130);
        drive_frame();
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL scale step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    task automatic test_clip();
        act_q.delete(); exp_q.delete();
        wr(0, 8'h57);  wr(1, 8'h3C);  wr(2, 8'hA9);
        set_cfg(1'b1, 1900, 0, 0, 1'b0);
        llen.delete();
        repeat (3) llen.push_back(1920);
        drive_frame();
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL clip step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    task automatic test_midframe();
        act_q.delete(); exp_q.delete();
        set_cfg(1'b1, 10, 0, 0, 1'b0);
        llen.delete();
        repeat (6) llen.push_back(80);
        mid_line = 3;  mid_ox = 40;
        drive_frame();
        mid_line = -1;
        drive_frame();
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL midframe step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    task automatic test_transparent();
        act_q.delete(); exp_q.delete();
        rgb_mode = 1;
        set_cfg(1'b1, 5, 0, 1, 1'b1);
        llen.delete();
        repeat (4) llen.push_back(100);
        drive_frame();
        set_cfg(1'b0, 5, 0, 1, 1'b0);
        drive_frame();
        rgb_mode = 0;
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL transparent step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    task automatic test_random();
        act_q.delete(); exp_q.delete();
        repeat (2) begin
            repeat (12) wr($urandom_range(0, COLS * ROWS - 1), 8'($urandom));
            set_cfg(1'($urandom), $urandom_range(0, 200), $urandom_range(0, 10),
                    $urandom_range(0, 3), 1'($urandom));
            llen.delete();
            repeat (30) llen.push_back($urandom_range(1, 400));
            drive_frame();
        end
        for (int n = 0; n + 3 < act_q.size(); n++) begin
            tests++;
            if (act_q[n+3] !== exp_q[n]) begin
                fails++;
                if (fails <= 10) $display("FAIL random step %0d: got %h required %h", n, act_q[n+3], exp_q[n]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;  in_de = 1'b0;  in_hs = 1'b0;  in_vs = 1'b0;  in_rgb = '0;
        ov_enable = 1'b0;  ov_x = '0;  ov_y = '0;  ov_scale = '0;
        fg_rgb = '0;  bg_rgb = '0;  bg_transparent = 1'b0;
        chr_we = 1'b0;  chr_addr = '0;  chr_data = '0;
        test_reset();
        test_clear_map();
        test_glyph();
        test_scale();
        test_clip();
        test_midframe();
        test_transparent();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
